mul_div_unit: RTL and testbench

//  Iterative RV32M multiply/divide execution unit; sits beside the ALU, downstream of ALU_Control and the decoder.

---
 rtl/mul_div_unit_pkg.sv | 34 +++
 rtl/mul_div_unit_if.sv | 22 ++
 rtl/mul_div_unit_abs_value.sv | 13 +
 rtl/mul_div_unit.sv | 186 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings, FSM states and
// operand signedness decode.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } md_state_e;

  function automatic logic is_div(md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic rs1_signed(md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic rs2_signed(md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the decode stage (master) and the mul/div unit (slave).
interface mul_div_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start_i;
  logic [2:0]            op_i;
  logic [DATA_WIDTH-1:0] rs1_data_i;
  logic [DATA_WIDTH-1:0] rs2_data_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, rs1_data_i, rs2_data_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs1_data_i, rs2_data_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/mul_div_unit_abs_value.sv
// Converts an operand to its magnitude; neg_o flags a negative signed input.
module mul_div_unit_abs_value #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic                  signed_i,
  output logic [DATA_WIDTH-1:0] mag_o,
  output logic                  neg_o
);
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign neg_o = signed_i & value_i[DATA_WIDTH-1];
  assign mag_o = neg_o ? (~value_i + 1'b1) : value_i;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle,
// with a one-cycle fast path for the architecturally defined divide special cases.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  mul_div_unit_if.slave bus
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam logic [5:0] LastIter = 6'(DATA_WIDTH - 1);
  localparam logic [DW-1:0] MinNeg = {1'b1, {(DW - 1){1'b0}}};

  md_state_e       state_q, state_d;
  md_op_e          op_q, op_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [DW-1:0]   opb_q, opb_d;
  logic [DW-1:0]   result_q, result_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            special_q, special_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  md_op_e        op_in;
  logic [DW-1:0] mag1, mag2;
  logic          neg1, neg2;

  assign op_in = md_op_e'(bus.op_i);

  mul_div_unit_abs_value #(.DATA_WIDTH(DW)) u_abs_rs1 (
    .value_i  (bus.rs1_data_i),
    .signed_i (rs1_signed(op_in)),
    .mag_o    (mag1),
    .neg_o    (neg1)
  );

  mul_div_unit_abs_value #(.DATA_WIDTH(DW)) u_abs_rs2 (
    .value_i  (bus.rs2_data_i),
    .signed_i (rs2_signed(op_in)),
    .mag_o    (mag2),
    .neg_o    (neg2)
  );

  // Special-case detection at acceptance
  logic          div_by_zero, div_ovf, special_in;
  logic [DW-1:0] special_val;

  always_comb begin
    div_by_zero = is_div(op_in) && (bus.rs2_data_i == '0);
    div_ovf     = (op_in == MD_DIV || op_in == MD_REM) &&
                  (bus.rs1_data_i == MinNeg) && (bus.rs2_data_i == '1);
    special_in  = div_by_zero || div_ovf;
    special_val = '0;
    if (div_by_zero) begin
      special_val = (op_in == MD_DIV || op_in == MD_DIVU) ? '1 : bus.rs1_data_i;
    end else if (div_ovf) begin
      special_val = (op_in == MD_DIV) ? MinNeg : '0;
    end
  end

  // Per-iteration datapath. Multiply keeps {partial product, multiplier}; divide keeps
  // {remainder, dividend/quotient}.
  logic [DW-1:0] mul_addend, div_diff;
  logic [DW:0]   mul_sum, div_tmp;
  logic          div_ge;

  always_comb begin
    mul_addend = acc_q[0] ? opb_q : '0;
    mul_sum    = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, mul_addend};
    div_tmp    = acc_q[2*DW-1:DW-1];
    div_ge     = div_tmp >= {1'b0, opb_q};
    div_diff   = div_tmp[DW-1:0] - opb_q;
  end

  // Sign correction of the finished magnitude
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   quo, rem, fix_result;

  always_comb begin
    prod = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo  = neg_res_q ? (~acc_q[DW-1:0] + 1'b1) : acc_q[DW-1:0];
    rem  = neg_rem_q ? (~acc_q[2*DW-1:DW] + 1'b1) : acc_q[2*DW-1:DW];
    if (special_q) begin
      fix_result = acc_q[DW-1:0];
    end else begin
      unique case (op_q)
        MD_MUL:                        fix_result = prod[DW-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU:  fix_result = prod[2*DW-1:DW];
        MD_DIV, MD_DIVU:               fix_result = quo;
        MD_REM, MD_REMU:               fix_result = rem;
        default:                       fix_result = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    result_d  = result_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    special_d = special_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          op_d      = op_in;
          cnt_d     = '0;
          neg_res_d = neg1 ^ neg2;
          neg_rem_d = neg1;
          special_d = special_in;
          if (special_in) begin
            acc_d   = {{DW{1'b0}}, special_val};
            state_d = StFix;
          end else begin
            acc_d   = {{DW{1'b0}}, is_div(op_in) ? mag1 : mag2};
            opb_d   = is_div(op_in) ? mag2 : mag1;
            busy_d  = 1'b1;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 6'd1;
        if (is_div(op_q)) begin
          acc_d = div_ge ? {div_diff, acc_q[DW-2:0], 1'b1}
                         : {div_tmp[DW-1:0], acc_q[DW-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[DW-1:1]};
        end
        if (cnt_q == LastIter) begin
          busy_d  = 1'b0;
          state_d = StFix;
        end
      end
      StFix: begin
        result_d = fix_result;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      op_q      <= MD_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      special_q <= special_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M vectors, randomized ops against an
// arithmetic reference model, start-ignore, back-to-back and mid-operation reset scenarios.
module tb_mul_div_unit;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if #(.DATA_WIDTH(DW)) bus ();

  mul_div_unit #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model straight from the RV32M definitions using wide native arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin up = {32'h0, a} * {32'h0, b}; return up[31:0]; end
      3'd1: begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
      3'd2: begin sp = longint'(sa) * longint'({32'h0, b}); return sp[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called just after a falling edge; the request is sampled on the next rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // n = rising edges after the accepting edge until done_o is seen (bounded at 100).
  task automatic wait_done(input int repulse_at, output logic [31:0] res, output int n,
                           output int busyc, output bit glitch);
    logic [31:0] r0;
    r0     = bus.result_o;
    n      = 0;
    busyc  = 0;
    glitch = 1'b0;
    while (bus.done_o !== 1'b1 && n < 100) begin
      if (bus.busy_o === 1'b1) busyc++;
      if (bus.result_o !== r0) glitch = 1'b1;
      if (n == repulse_at) begin
        bus.start_i    = 1'b1;
        bus.op_i       = 3'd0;
        bus.rs1_data_i = $urandom;
        bus.rs2_data_i = $urandom;
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start_i = 1'b0;
    res         = bus.result_o;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int n, output int busyc,
                        output bit glitch);
    @(negedge clk);
    issue(op, a, b);
    wait_done(-1, res, n, busyc, glitch);
  endtask

  task automatic test_reset();
    bus.start_i    = 1'b0;
    bus.op_i       = 3'd0;
    bus.rs1_data_i = '0;
    bus.rs2_data_i = '0;
    reset          = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy_o, bus.done_o, bus.result_o} !== 34'h0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000",
               bus.busy_o, bus.done_o, bus.result_o);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd7, 3'd4, 3'd6,
                              3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [12] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd100,
                              32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
                              32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2, 32'd7, 32'd7,
                              32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exs [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF,
                              32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd5, 32'h8000_0000, 32'h0};
    int          lats [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] res;
    int          n, busyc;
    bit          glitch;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], as[i], bs[i], res, n, busyc, glitch);
      n_cmp++;
      if (res !== exs[i]) begin
        n_bad++;
        $display("FAIL directed_result[%0d] op=%0d: got %h, required %h", i, ops[i], res,
                 exs[i]);
      end
      n_cmp++;
      if (n != lats[i] || busyc != ((lats[i] == 1) ? 0 : 32)) begin
        n_bad++;
        $display("FAIL directed_timing[%0d]: done after %0d edges busy %0d cycles, required %0d/%0d",
                 i, n, busyc, lats[i], (lats[i] == 1) ? 0 : 32);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.done_o !== 1'b0 || bus.result_o !== exs[i]) begin
        n_bad++;
        $display("FAIL directed_after_done[%0d]: done=%b result=%h, required 0 %h", i,
                 bus.done_o, bus.result_o, exs[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, res, exp;
    int          n, busyc, exp_n;
    bit          glitch;
    for (int i = 0; i < 150; i++) begin
      op    = 3'($urandom_range(0, 7));
      a     = pick_operand();
      b     = pick_operand();
      exp   = model(op, a, b);
      exp_n = is_fast(op, a, b) ? 1 : 33;
      run_op(op, a, b, res, n, busyc, glitch);
      n_cmp++;
      if (res !== exp || n != exp_n || glitch) begin
        n_bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h after %0d glitch=%0b, required %h after %0d",
                 i, op, a, b, res, n, glitch, exp, exp_n);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] res;
    int          n, busyc;
    bit          glitch;
    @(negedge clk);
    issue(3'd5, 32'd1000, 32'd10);
    wait_done(5, res, n, busyc, glitch);
    n_cmp++;
    if (res !== 32'd100 || n != 33 || glitch) begin
      n_bad++;
      $display("FAIL ignore_start: got %h after %0d glitch=%0b, required 00000064 after 33",
               res, n, glitch);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int          n, busyc;
    bit          glitch;
    run_op(3'd0, 32'd1234, 32'd5678, res, n, busyc, glitch);
    n_cmp++;
    if (res !== 32'd7006652) begin
      n_bad++;
      $display("FAIL b2b_first: got %h, required %h", res, 32'd7006652);
    end
    issue(3'd6, 32'hFFFF_FF9C, 32'd7);
    wait_done(-1, res, n, busyc, glitch);
    n_cmp++;
    if (res !== 32'hFFFF_FFFE || n != 33 || busyc != 32) begin
      n_bad++;
      $display("FAIL b2b_second: got %h after %0d busy %0d, required fffffffe after 33 busy 32",
               res, n, busyc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          n, busyc;
    bit          glitch;
    bit          saw_done;
    run_op(3'd0, 32'd3, 32'd5, res, n, busyc, glitch);
    @(negedge clk);
    issue(3'd5, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.result_o !== 32'h0 || bus.done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h, required 0 0 00000000",
               bus.busy_o, bus.done_o, bus.result_o);
    end
    saw_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: done/busy seen after reset, required none");
    end
    run_op(3'd7, 32'd1000, 32'd7, res, n, busyc, glitch);
    n_cmp++;
    if (res !== 32'd6 || n != 33) begin
      n_bad++;
      $display("FAIL reset_mid_next: got %h after %0d, required 00000006 after 33", res, n);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
